// File: rtl/cy_status_reg_sticky_if.sv
// Bus-side port bundle for the sticky status register: read handshake, mask write, interrupt.
interface cy_status_reg_sticky_if #(
    parameter int WIDTH = 8
);
    logic             rd_req;
    logic             rd_ack;
    logic [WIDTH-1:0] rd_data;
    logic             mask_wr;
    logic [WIDTH-1:0] mask_wdata;
    logic             irq;

    modport master (
        output rd_req, mask_wr, mask_wdata,
        input  rd_ack, rd_data, irq
    );

    modport slave (
        input  rd_req, mask_wr, mask_wdata,
        output rd_ack, rd_data, irq
    );
endinterface

// File: rtl/cy_status_reg_sticky.sv
// Status register with per-bit sticky/transparent mode, read-to-clear snapshot,
// optional 2-flop input synchronizer and a masked, registered level interrupt.
module cy_status_reg_sticky #(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] STICKY_MASK  = '0,
    parameter bit               SYNC_EN      = 1'b1,
    parameter logic [WIDTH-1:0] INT_MASK_RST = '0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     status,
    cy_status_reg_sticky_if.slave bus,
    output logic [1:0]           dbg_state,
    output logic [WIDTH-1:0]     dbg_status,
    output logic [WIDTH-1:0]     dbg_mask
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SNAP    = 2'd1,
        ACK     = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sample;
    logic [WIDTH-1:0] status_q;
    logic [WIDTH-1:0] status_next;
    logic [WIDTH-1:0] snapshot_q;
    logic [WIDTH-1:0] mask_q;
    logic             rd_ack_q;
    logic             irq_q;

    if (SYNC_EN) begin : g_sync
        logic [WIDTH-1:0] sync_meta;
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                sync_meta <= '0;
                sample    <= '0;
            end else begin
                sync_meta <= status;
                sample    <= sync_meta;
            end
        end
    end else begin : g_nosync
        always_ff @(posedge clock or posedge reset) begin
            if (reset) sample <= '0;
            else       sample <= status;
        end
    end

    // In SNAP a captured sticky 1 clears, but a sample of 1 in that cycle re-sets it.
    always_comb begin
        status_next = (sample & ~STICKY_MASK)
                    | (STICKY_MASK & ((state == SNAP) ? sample : (status_q | sample)));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            status_q <= '0;
            mask_q   <= INT_MASK_RST;
            irq_q    <= 1'b0;
        end else begin
            status_q <= status_next;
            irq_q    <= |(status_q & mask_q);
            if (bus.mask_wr) mask_q <= bus.mask_wdata;
        end
    end

    // rd_req is a level request; rd_ack pulses once per request, carrying rd_data,
    // and a new read starts only after rd_req has been seen low in RELEASE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            rd_ack_q   <= 1'b0;
            snapshot_q <= '0;
        end else begin
            rd_ack_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.rd_req) state <= SNAP;
                end
                SNAP: begin
                    state      <= ACK;
                    rd_ack_q   <= 1'b1;
                    snapshot_q <= status_q;
                end
                ACK: begin
                    state <= RELEASE;
                end
                RELEASE: begin
                    if (!bus.rd_req) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rd_ack  = rd_ack_q;
    assign bus.rd_data = snapshot_q;
    assign bus.irq     = irq_q;
    assign dbg_state   = state;
    assign dbg_status  = status_q;
    assign dbg_mask    = mask_q;

endmodule

// File: tb/tb_cy_status_reg_sticky.sv
// Directed bench for cy_status_reg_sticky: sticky/transparent capture, read-to-clear,
// single-ack handshake, interrupt masking and asynchronous reset mid-read.
module tb_cy_status_reg_sticky;

    localparam int         WIDTH    = 8;
    localparam logic [7:0] STICKY   = 8'h0F;
    localparam logic [7:0] MASK_RST = 8'h80;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SNAP = 2'd1;

    logic             clock;
    logic             reset;
    logic [WIDTH-1:0] status;
    logic [1:0]       dbg_state;
    logic [WIDTH-1:0] dbg_status;
    logic [WIDTH-1:0] dbg_mask;

    int assert_count = 0;
    int fail_count   = 0;

    cy_status_reg_sticky_if #(.WIDTH(WIDTH)) bus ();

    cy_status_reg_sticky #(
        .WIDTH        (WIDTH),
        .STICKY_MASK  (STICKY),
        .SYNC_EN      (1'b1),
        .INT_MASK_RST (MASK_RST)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .status     (status),
        .bus        (bus),
        .dbg_state  (dbg_state),
        .dbg_status (dbg_status),
        .dbg_mask   (dbg_mask)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assert_count++;
        if (got !== exp) begin
            fail_count++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_read(output logic [WIDTH-1:0] data);
        bus.rd_req = 1'b1;
        tick();
        check("rd_lat1_ack", bus.rd_ack, 1'b0);
        check("rd_lat1_state", dbg_state, ST_SNAP);
        tick();
        check("rd_lat2_ack", bus.rd_ack, 1'b1);
        data = bus.rd_data;
        bus.rd_req = 1'b0;
        tick();
        check("rd_ack_pulse", bus.rd_ack, 1'b0);
        tick();
        check("rd_back_idle", dbg_state, ST_IDLE);
    endtask

    logic [WIDTH-1:0] d;
    int               n_ack;

    initial begin
        reset          = 1'b1;
        status         = '0;
        bus.rd_req     = 1'b0;
        bus.mask_wr    = 1'b0;
        bus.mask_wdata = '0;
        tick();
        tick();
        check("rst_ack", bus.rd_ack, 1'b0);
        check("rst_data", bus.rd_data, 8'h00);
        check("rst_irq", bus.irq, 1'b0);
        check("rst_state", dbg_state, ST_IDLE);
        check("rst_mask", dbg_mask, MASK_RST);
        check("rst_status", dbg_status, 8'h00);
        reset = 1'b0;

        // One-cycle pulse on sticky bit0 is latched and held
        status = 8'h01;
        tick();
        status = 8'h00;
        tick();
        check("stk_not_yet", dbg_status, 8'h00);
        tick();
        check("stk_set", dbg_status, 8'h01);
        tick();
        tick();
        check("stk_hold", dbg_status, 8'h01);

        // Transparent upper bits follow status
        status = 8'hA0;
        tick();
        tick();
        check("trn_not_yet", dbg_status, 8'h01);
        tick();
        check("trn_a0", dbg_status, 8'hA1);
        status = 8'h50;
        repeat (3) tick();
        check("trn_50", dbg_status, 8'h51);
        status = 8'h00;
        repeat (3) tick();
        check("trn_00", dbg_status, 8'h01);

        // Read clears the sticky bit; rd_data holds between reads
        do_read(d);
        check("rd1_data", d, 8'h01);
        check("rd1_hold", bus.rd_data, 8'h01);
        check("rd1_cleared", dbg_status, 8'h00);
        do_read(d);
        check("rd2_data", d, 8'h00);

        // Set wins over clear when sample is 1 during SNAP
        status = 8'h01;
        repeat (3) tick();
        do_read(d);
        check("sw_rd_data", d, 8'h01);
        status = 8'h00;
        repeat (3) tick();
        check("sw_kept", dbg_status, 8'h01);
        do_read(d);
        check("sw_rd2_data", d, 8'h01);
        do_read(d);
        check("sw_rd3_data", d, 8'h00);

        // rd_req held for 10 cycles gives exactly one ack
        n_ack = 0;
        bus.rd_req = 1'b1;
        repeat (10) begin
            tick();
            if (bus.rd_ack) n_ack++;
        end
        bus.rd_req = 1'b0;
        repeat (3) begin
            tick();
            if (bus.rd_ack) n_ack++;
        end
        check("one_ack", n_ack, 1);
        check("held_idle", dbg_state, ST_IDLE);

        // rd_req dropped during SNAP does not abort
        bus.rd_req = 1'b1;
        tick();
        bus.rd_req = 1'b0;
        tick();
        check("no_abort_ack", bus.rd_ack, 1'b1);
        tick();
        tick();
        check("no_abort_idle", dbg_state, ST_IDLE);

        // Interrupt mask write and clear
        status = 8'h02;
        tick();
        status = 8'h00;
        repeat (3) tick();
        check("b1_set", dbg_status, 8'h02);
        check("irq_masked", bus.irq, 1'b0);
        bus.mask_wr    = 1'b1;
        bus.mask_wdata = 8'h02;
        tick();
        bus.mask_wr = 1'b0;
        check("mask_loaded", dbg_mask, 8'h02);
        check("irq_lag", bus.irq, 1'b0);
        tick();
        check("irq_on", bus.irq, 1'b1);
        bus.mask_wr    = 1'b1;
        bus.mask_wdata = 8'h00;
        tick();
        bus.mask_wr = 1'b0;
        check("irq_still_on", bus.irq, 1'b1);
        tick();
        check("irq_off", bus.irq, 1'b0);

        // Mask write coinciding with SNAP: both take effect
        bus.rd_req = 1'b1;
        tick();
        bus.mask_wr    = 1'b1;
        bus.mask_wdata = 8'h02;
        tick();
        bus.mask_wr = 1'b0;
        bus.rd_req  = 1'b0;
        check("snapmw_ack", bus.rd_ack, 1'b1);
        check("snapmw_data", bus.rd_data, 8'h02);
        check("snapmw_mask", dbg_mask, 8'h02);
        check("snapmw_clr", dbg_status, 8'h00);
        tick();
        check("snapmw_irq", bus.irq, 1'b0);
        tick();

        // Asynchronous reset in ACK
        status = 8'h02;
        tick();
        status = 8'h00;
        repeat (4) tick();
        check("pre_rst_irq", bus.irq, 1'b1);
        bus.rd_req = 1'b1;
        tick();
        tick();
        check("pre_rst_ack", bus.rd_ack, 1'b1);
        #1 reset = 1'b1;
        #1;
        check("arst_ack", bus.rd_ack, 1'b0);
        check("arst_irq", bus.irq, 1'b0);
        check("arst_data", bus.rd_data, 8'h00);
        check("arst_mask", dbg_mask, MASK_RST);
        check("arst_state", dbg_state, ST_IDLE);
        bus.rd_req = 1'b0;
        tick();
        reset = 1'b0;
        n_ack = 0;
        repeat (3) begin
            tick();
            if (bus.rd_ack) n_ack++;
        end
        check("post_rst_no_ack", n_ack, 0);
        check("post_rst_idle", dbg_state, ST_IDLE);
        check("post_rst_status", dbg_status, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
